// File: rtl/sdram_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sdram_pkg : command codes, burst length and FSM encodings shared by the
//             single-bank SDRAM controller engines.          Rev 1.0
// -----------------------------------------------------------------------------
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0]  CMD_NOP     = 4'b0111;
  localparam logic [3:0]  CMD_PRE     = 4'b0010;
  localparam logic [3:0]  CMD_ACT     = 4'b0011;
  localparam logic [3:0]  CMD_WR      = 4'b0100;

  localparam int          BL          = 4;
  localparam logic [11:0] A10_PRE_ALL = 12'h400;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_REQ  = 5'b00010,
    S_ACT  = 5'b00100,
    S_WR   = 5'b01000,
    S_PRE  = 5'b10000
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sdram_addr_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sdram_addr_gen : linear row/column burst address counter with row-end and
//                  data-end flags, wrapping to 0 after the final burst. Rev 1.0
// -----------------------------------------------------------------------------
module sdram_addr_gen
  import sdram_pkg::*;
#(
  parameter int ROW_ADDR_END  = 937,
  parameter int COL_MADDR_END = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        step_i,
  output logic [11:0] row_o,
  output logic [8:0]  col_o,
  output logic        row_end_o,
  output logic        data_end_o
);

  localparam logic [11:0] ROW_LAST    = 12'(ROW_ADDR_END);
  localparam logic [8:0]  COL_LAST    = 9'(COL_MADDR_END - BL);
  localparam logic [8:0]  COL_ROW_TOP = 9'(512 - BL);

  logic [11:0] row_q, row_d;
  logic [8:0]  col_q, col_d;
  logic        row_end_q, row_end_d;
  logic        data_end_q, data_end_d;
  logic        at_data_end, at_row_end;

  // Flags describe the burst just issued and hold until the next step.
  always_comb begin
    at_data_end = (row_q == ROW_LAST) && (col_q == COL_LAST);
    at_row_end  = (col_q == COL_ROW_TOP) && !at_data_end;
    row_d       = row_q;
    col_d       = col_q;
    row_end_d   = row_end_q;
    data_end_d  = data_end_q;
    if (step_i) begin
      row_end_d  = at_row_end;
      data_end_d = at_data_end;
      if (at_data_end) begin
        row_d = '0;
        col_d = '0;
      end else if (at_row_end) begin
        row_d = row_q + 12'd1;
        col_d = '0;
      end else begin
        col_d = col_q + 9'(BL);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q      <= '0;
      col_q      <= '0;
      row_end_q  <= 1'b0;
      data_end_q <= 1'b0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      row_end_q  <= row_end_d;
      data_end_q <= data_end_d;
    end
  end

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign row_end_o  = row_end_q;
  assign data_end_o = data_end_q;

endmodule
`default_nettype wire

// File: rtl/sdram_write.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sdram_write : write-path engine; drains the write FIFO as BL4 WRITE bursts
//               and yields the bus at burst boundaries on refresh.  Rev 1.0
// -----------------------------------------------------------------------------
module sdram_write
  import sdram_pkg::*;
#(
  parameter int WROW_ADDR_END  = 937,
  parameter int WCOL_MADDR_END = 256,
  parameter int TRCD           = 2,
  parameter int TRP            = 2
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        wr_trig,
  input  logic        wr_en,
  input  logic        aref_req,
  output logic        wr_req,
  output logic        wr_end,
  output logic [3:0]  wr_cmd,
  output logic [11:0] wr_addr,
  output logic [1:0]  bank_addr,
  input  logic [15:0] wfifo_rd_data,
  output logic        wfifo_rd_en,
  output logic [15:0] wr_dq,
  output logic        wr_dq_oe
);

  localparam logic [3:0] TRCD_LAST = 4'(TRCD - 1);
  localparam logic [3:0] TRP_LAST  = 4'(TRP - 1);

  state_e      state_q;
  logic [1:0]  burst_cnt_q;
  logic [3:0]  wait_cnt_q;
  logic        wr_req_q, wr_end_q, wr_dq_oe_q;
  logic [3:0]  wr_cmd_q;
  logic [11:0] wr_addr_q;
  logic [15:0] wr_dq_q;

  logic [11:0] row_addr;
  logic [8:0]  col_addr;
  logic        row_end, data_end, addr_step;

  assign addr_step = (state_q == S_WR) && (burst_cnt_q == 2'd0);

  sdram_addr_gen #(
    .ROW_ADDR_END  (WROW_ADDR_END),
    .COL_MADDR_END (WCOL_MADDR_END)
  ) u_addr_gen (
    .clk_i      (sclk),
    .rst_i      (rst),
    .step_i     (addr_step),
    .row_o      (row_addr),
    .col_o      (col_addr),
    .row_end_o  (row_end),
    .data_end_o (data_end)
  );

  // Outputs are registered from the current state, so every command and its
  // data word leave the block together one cycle after the state decides them.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      burst_cnt_q <= 2'd0;
      wait_cnt_q  <= 4'd0;
      wr_req_q    <= 1'b0;
      wr_end_q    <= 1'b0;
      wr_cmd_q    <= CMD_NOP;
      wr_addr_q   <= 12'd0;
      wr_dq_q     <= 16'd0;
      wr_dq_oe_q  <= 1'b0;
    end else begin
      wr_end_q   <= 1'b0;
      wr_cmd_q   <= CMD_NOP;
      wr_dq_oe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_trig) begin
            state_q  <= S_REQ;
            wr_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (wr_en) begin
            wr_req_q   <= 1'b0;
            state_q    <= S_ACT;
            wait_cnt_q <= 4'd0;
          end
        end
        S_ACT: begin
          if (wait_cnt_q == 4'd0) begin
            wr_cmd_q  <= CMD_ACT;
            wr_addr_q <= row_addr;
          end
          if (wait_cnt_q == TRCD_LAST) begin
            state_q     <= S_WR;
            burst_cnt_q <= 2'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        S_WR: begin
          wr_dq_q     <= wfifo_rd_data;
          wr_dq_oe_q  <= 1'b1;
          burst_cnt_q <= burst_cnt_q + 2'd1;
          if (burst_cnt_q == 2'd0) begin
            wr_cmd_q  <= CMD_WR;
            wr_addr_q <= {3'b000, col_addr};
          end
          if ((burst_cnt_q == 2'd3) && (data_end || row_end || aref_req)) begin
            state_q    <= S_PRE;
            wait_cnt_q <= 4'd0;
          end
        end
        S_PRE: begin
          if (wait_cnt_q == 4'd0) begin
            wr_cmd_q  <= CMD_PRE;
            wr_addr_q <= A10_PRE_ALL;
          end
          if (wait_cnt_q == TRP_LAST) begin
            wait_cnt_q <= 4'd0;
            if (data_end) begin
              state_q  <= S_IDLE;
              wr_end_q <= 1'b1;
            end else if (aref_req) begin
              state_q  <= S_REQ;
              wr_req_q <= 1'b1;
              wr_end_q <= 1'b1;
            end else begin
              state_q <= S_ACT;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wfifo_rd_en = (state_q == S_WR);
  assign bank_addr   = 2'b00;
  assign wr_req      = wr_req_q;
  assign wr_end      = wr_end_q;
  assign wr_cmd      = wr_cmd_q;
  assign wr_addr     = wr_addr_q;
  assign wr_dq       = wr_dq_q;
  assign wr_dq_oe    = wr_dq_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_write.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sdram_write : randomized bench for sdram_write against a burst-level
//                  address/data model of the SDRAM write bus.      Rev 1.0
// -----------------------------------------------------------------------------
module tb_sdram_write;
  import sdram_pkg::*;

  // Short address space so the run crosses row ends and the final wrap.
  localparam int ROW_END = 2;
  localparam int COL_END = 256;
  localparam int TRCD    = 2;
  localparam int TRP     = 2;

  logic        sclk = 1'b0;
  logic        rst, wr_trig, wr_en, aref_req;
  logic        wr_req, wr_end, wfifo_rd_en, wr_dq_oe;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  bank_addr;
  logic [15:0] wfifo_rd_data, wr_dq;

  sdram_write #(
    .WROW_ADDR_END  (ROW_END),
    .WCOL_MADDR_END (COL_END),
    .TRCD           (TRCD),
    .TRP            (TRP)
  ) dut (
    .sclk          (sclk),
    .rst           (rst),
    .wr_trig       (wr_trig),
    .wr_en         (wr_en),
    .aref_req      (aref_req),
    .wr_req        (wr_req),
    .wr_end        (wr_end),
    .wr_cmd        (wr_cmd),
    .wr_addr       (wr_addr),
    .bank_addr     (bank_addr),
    .wfifo_rd_data (wfifo_rd_data),
    .wfifo_rd_en   (wfifo_rd_en),
    .wr_dq         (wr_dq),
    .wr_dq_oe      (wr_dq_oe)
  );

  always #5 sclk = ~sclk;

  // Show-ahead FIFO: random words, head advances on every pop.
  logic [15:0] fifo_mem [0:1023];
  int unsigned rd_ptr = 0;
  assign wfifo_rd_data = fifo_mem[rd_ptr % 1024];
  always @(posedge sclk) if (wfifo_rd_en) rd_ptr <= rd_ptr + 1;

  int n_pass  = 0;
  int n_total = 0;
  int row_m, col_m;
  int unsigned exp_wi;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic wait_req();
    int n = 0;
    while (wr_req !== 1'b1 && n < 8) begin step(); n++; end
    check("wr_req_rise", {31'd0, wr_req}, 32'd1);
  endtask

  task automatic grant();
    int d = $urandom_range(0, 4);
    repeat (d) begin step(); check("wr_req_hold", {31'd0, wr_req}, 32'd1); end
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("wr_req_drop", {31'd0, wr_req}, 32'd0);
  endtask

  task automatic expect_act();
    int n = 0;
    while (wr_cmd === CMD_NOP && n < 8) begin step(); n++; end
    check("act_cmd", {28'd0, wr_cmd}, {28'd0, CMD_ACT});
    check("act_row", {20'd0, wr_addr}, row_m);
    check("act_oe", {31'd0, wr_dq_oe}, 32'd0);
    repeat (TRCD - 1) begin step(); check("trcd_nop", {28'd0, wr_cmd}, {28'd0, CMD_NOP}); end
    step();
  endtask

  // One BL4 burst at the model address; leaves the bench one cycle past it.
  task automatic burst(output bit de, output bit re);
    int p = (col_m >= 504) ? 1 : 15;
    check("wr_cmd", {28'd0, wr_cmd}, {28'd0, CMD_WR});
    check("wr_col", {20'd0, wr_addr}, col_m);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin step(); check("burst_nop", {28'd0, wr_cmd}, {28'd0, CMD_NOP}); end
      check("dq_oe", {31'd0, wr_dq_oe}, 32'd1);
      check("dq", {16'd0, wr_dq}, {16'd0, fifo_mem[exp_wi % 1024]});
      exp_wi++;
      if (j == 1 && !aref_req && $urandom_range(0, p) == 0) aref_req = 1'b1;
    end
    de = (row_m == ROW_END) && (col_m == COL_END - 4);
    re = !de && (col_m == 508);
    if (de) begin row_m = 0; col_m = 0; end
    else if (re) begin row_m++; col_m = 0; end
    else col_m += 4;
    step();
  endtask

  // Runs from wr_trig until the data-end release of the bus.
  task automatic session();
    bit de, re, done, yield;
    wr_trig = 1'b1;
    wait_req();
    wr_trig = 1'b0;
    grant();
    done = 1'b0;
    while (!done) begin
      expect_act();
      do burst(de, re); while (!de && !re && !aref_req);
      check("pre_cmd", {28'd0, wr_cmd}, {28'd0, CMD_PRE});
      check("pre_addr", {20'd0, wr_addr}, 32'h400);
      check("pre_oe", {31'd0, wr_dq_oe}, 32'd0);
      repeat (TRP - 1) step();
      yield = de || aref_req;
      check("wr_end", {31'd0, wr_end}, {31'd0, yield});
      check("post_pre_oe", {31'd0, wr_dq_oe}, 32'd0);
      if (de) begin
        check("idle_req", {31'd0, wr_req}, 32'd0);
        aref_req = 1'b0;
        step();
        check("wr_end_1cyc", {31'd0, wr_end}, 32'd0);
        done = 1'b1;
      end else if (aref_req) begin
        check("yield_req", {31'd0, wr_req}, 32'd1);
        aref_req = 1'b0;
        step();
        check("wr_end_1cyc", {31'd0, wr_end}, 32'd0);
        grant();
      end else begin
        step();
        check("trp_act", {28'd0, wr_cmd}, {28'd0, CMD_ACT});
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit de, re;
    for (int i = 0; i < 1024; i++) fifo_mem[i] = 16'($urandom);
    rst = 1'b1; wr_trig = 1'b0; wr_en = 1'b0; aref_req = 1'b0;
    repeat (3) step();
    check("rst_cmd", {28'd0, wr_cmd}, {28'd0, CMD_NOP});
    check("rst_addr", {20'd0, wr_addr}, 32'd0);
    check("rst_dq", {16'd0, wr_dq}, 32'd0);
    check("rst_oe", {31'd0, wr_dq_oe}, 32'd0);
    check("rst_req", {31'd0, wr_req}, 32'd0);
    check("rst_end", {31'd0, wr_end}, 32'd0);
    check("rst_rd_en", {31'd0, wfifo_rd_en}, 32'd0);
    check("bank", {30'd0, bank_addr}, 32'd0);
    rst = 1'b0;
    step();
    row_m = 0; col_m = 0; exp_wi = 0;

    session();
    session();

    // Reset in the middle of a burst.
    wr_trig = 1'b1;
    wait_req();
    wr_trig = 1'b0;
    grant();
    expect_act();
    check("wr_cmd", {28'd0, wr_cmd}, {28'd0, CMD_WR});
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_cmd", {28'd0, wr_cmd}, {28'd0, CMD_NOP});
    check("abort_oe", {31'd0, wr_dq_oe}, 32'd0);
    check("abort_rd_en", {31'd0, wfifo_rd_en}, 32'd0);
    check("abort_req", {31'd0, wr_req}, 32'd0);
    check("abort_addr", {20'd0, wr_addr}, 32'd0);
    step();
    check("abort_idle", {31'd0, wr_req}, 32'd0);
    check("abort_idle_rd", {31'd0, wfifo_rd_en}, 32'd0);

    // Address restarts at row 0 / col 0 after reset.
    row_m = 0; col_m = 0; exp_wi = rd_ptr;
    wr_trig = 1'b1;
    wait_req();
    wr_trig = 1'b0;
    grant();
    expect_act();
    burst(de, re);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
